// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_cell.sv
// full_sub_cell: 1-bit full subtractor, d = x - y - c with borrow-out bo
module full_sub_cell (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic c
);
  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~(x ^ y) & c);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock with start/busy/done
import serial_sub_pkg::*;
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, sr;
  logic [CW-1:0] cnt;
  logic brw, d, bo, accept, last;
  full_sub_cell u_cell (.d(d), .bo(bo), .x(ra[0]), .y(rb[0]), .c(brw));
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
  always_comb begin
    accept  = start && state != ST_RUN;
    last    = busy && cnt == CW'(WIDTH - 1);
    state_n = accept ? ST_RUN : last ? ST_DONE : busy ? ST_RUN : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  // Result registers update only on the completion edge so they hold the previous result during RUN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      sr   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      ra  <= a;
      rb  <= b;
      brw <= bin;
      cnt <= '0;
    end else if (busy) begin
      ra  <= {1'b0, ra[WIDTH-1:1]};
      rb  <= {1'b0, rb[WIDTH-1:1]};
      sr  <= {d, sr[WIDTH-1:1]};
      brw <= bo;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= {d, sr[WIDTH-1:1]};
        bout <= bo;
      end
    end
endmodule
